// File: rtl/pwl_act_pkg.sv
// Shared types and fixed-point constants for the piecewise-linear activation pipe.
// Constants scale with frac_w (1.0 = 2^frac_w); the smallest fraction used needs frac_w >= 5.
package pwl_act_pkg;

  typedef enum logic [1:0] {
    MODE_SIGMOID = 2'd0,
    MODE_TANH    = 2'd1,
    MODE_RELU    = 2'd2,
    MODE_BYPASS  = 2'd3
  } pwl_mode_e;

  typedef enum logic [1:0] {
    SEG_LOW  = 2'd0,
    SEG_MID  = 2'd1,
    SEG_HIGH = 2'd2,
    SEG_SAT  = 2'd3
  } pwl_seg_e;

  localparam int unsigned SHIFT_HIGH = 5;
  localparam int unsigned SHIFT_MID  = 3;
  localparam int unsigned SHIFT_LOW  = 2;

  function automatic int unsigned pwl_one(input int unsigned frac_w);
    return 32'd1 << frac_w;
  endfunction

  // 5.0
  function automatic int unsigned pwl_bp_sat(input int unsigned frac_w);
    return 32'd5 << frac_w;
  endfunction

  // 2.375 = 19/8
  function automatic int unsigned pwl_bp_high(input int unsigned frac_w);
    return 32'd19 << (frac_w - 3);
  endfunction

  // 1.0
  function automatic int unsigned pwl_bp_mid(input int unsigned frac_w);
    return 32'd1 << frac_w;
  endfunction

  // 0.84375 = 27/32
  function automatic int unsigned pwl_icpt_high(input int unsigned frac_w);
    return 32'd27 << (frac_w - 5);
  endfunction

  // 0.625 = 5/8
  function automatic int unsigned pwl_icpt_mid(input int unsigned frac_w);
    return 32'd5 << (frac_w - 3);
  endfunction

  // 0.5
  function automatic int unsigned pwl_icpt_low(input int unsigned frac_w);
    return 32'd1 << (frac_w - 1);
  endfunction

endpackage

// File: rtl/pwl_seg_eval.sv
// Sigmoid PWL core on a non-negative magnitude: segment select and shift-add evaluate.
// The two halves are independent so select and evaluate can sit in adjacent stages.
module pwl_seg_eval
  import pwl_act_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 12
) (
  input  logic [DATA_W+1:0] sel_a,
  output pwl_seg_e          sel_seg,
  input  logic [DATA_W+1:0] eval_a,
  input  pwl_seg_e          eval_seg,
  output logic [DATA_W+1:0] eval_s
);

  localparam int unsigned AW = DATA_W + 2;

  localparam logic [AW-1:0] ONE        = AW'(pwl_one(FRAC_W));
  localparam logic [AW-1:0] BP_SAT     = AW'(pwl_bp_sat(FRAC_W));
  localparam logic [AW-1:0] BP_HIGH    = AW'(pwl_bp_high(FRAC_W));
  localparam logic [AW-1:0] BP_MID     = AW'(pwl_bp_mid(FRAC_W));
  localparam logic [AW-1:0] ICPT_HIGH  = AW'(pwl_icpt_high(FRAC_W));
  localparam logic [AW-1:0] ICPT_MID   = AW'(pwl_icpt_mid(FRAC_W));
  localparam logic [AW-1:0] ICPT_LOW   = AW'(pwl_icpt_low(FRAC_W));

  always_comb begin
    sel_seg = SEG_LOW;
    if (sel_a >= BP_SAT) begin
      sel_seg = SEG_SAT;
    end else if (sel_a >= BP_HIGH) begin
      sel_seg = SEG_HIGH;
    end else if (sel_a >= BP_MID) begin
      sel_seg = SEG_MID;
    end
  end

  // Below the saturation breakpoint the sums stay well under 2^AW.
  always_comb begin
    eval_s = ONE;
    case (eval_seg)
      SEG_HIGH: eval_s = (eval_a >> SHIFT_HIGH) + ICPT_HIGH;
      SEG_MID:  eval_s = (eval_a >> SHIFT_MID) + ICPT_MID;
      SEG_LOW:  eval_s = (eval_a >> SHIFT_LOW) + ICPT_LOW;
      default:  eval_s = ONE;
    endcase
  end

endmodule

// File: rtl/pwl_act_pipe.sv
// Three-stage activation pipe (sigmoid/tanh/relu/bypass) with a global-stall handshake.
// S1 captures magnitude/sign/mode, S2 selects the segment, S3 evaluates and drives the outputs.
module pwl_act_pipe
  import pwl_act_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 12,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [1:0]        mode_in,
  input  logic [DATA_W-1:0] x_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] y_out,
  output logic [TAG_W-1:0]  tag_out
);

  localparam int unsigned AW = DATA_W + 2;
  localparam int unsigned RW = DATA_W + 4;

  localparam logic signed [RW-1:0] ONE_R = RW'(pwl_one(FRAC_W));
  localparam logic signed [RW-1:0] MAX_R = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_R = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic advance;

  logic              s1_valid_q, s1_valid_d;
  pwl_mode_e         s1_mode_q,  s1_mode_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
  logic              s1_neg_q,   s1_neg_d;
  logic [AW-1:0]     s1_a_q,     s1_a_d;
  logic [DATA_W-1:0] s1_x_q,     s1_x_d;

  logic              s2_valid_q, s2_valid_d;
  pwl_mode_e         s2_mode_q,  s2_mode_d;
  logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
  logic              s2_neg_q,   s2_neg_d;
  logic [AW-1:0]     s2_a_q,     s2_a_d;
  logic [DATA_W-1:0] s2_x_q,     s2_x_d;
  pwl_seg_e          s2_seg_q,   s2_seg_d;

  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] y_out_q,     y_out_d;
  logic [TAG_W-1:0]  tag_out_q,   tag_out_d;

  pwl_mode_e         mode_cur;
  logic [DATA_W:0]   x_ext;
  logic [DATA_W:0]   abs_x;
  pwl_seg_e          sel_seg;
  logic [AW-1:0]     eval_s;
  logic signed [RW-1:0] s_r, t_r, x_r, res_r;

  assign advance   = !valid_out_q || ready_out;
  assign ready_in  = advance;
  assign valid_out = valid_out_q;
  assign y_out     = y_out_q;
  assign tag_out   = tag_out_q;

  pwl_seg_eval #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_seg_eval (
    .sel_a    (s1_a_q),
    .sel_seg  (sel_seg),
    .eval_a   (s2_a_q),
    .eval_seg (s2_seg_q),
    .eval_s   (eval_s)
  );

  // Tanh reuses the sigmoid core on 2|x|, so the doubling happens before segment select.
  always_comb begin
    mode_cur = pwl_mode_e'(mode_in);
    x_ext    = {x_in[DATA_W-1], x_in};
    abs_x    = x_in[DATA_W-1] ? -x_ext : x_ext;

    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_tag_d   = s1_tag_q;
    s1_neg_d   = s1_neg_q;
    s1_a_d     = s1_a_q;
    s1_x_d     = s1_x_q;
    if (advance) begin
      s1_valid_d = valid_in;
      s1_mode_d  = mode_cur;
      s1_tag_d   = tag_in;
      s1_neg_d   = x_in[DATA_W-1];
      s1_x_d     = x_in;
      s1_a_d     = (mode_cur == MODE_TANH) ? {abs_x, 1'b0} : {1'b0, abs_x};
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_tag_d   = s2_tag_q;
    s2_neg_d   = s2_neg_q;
    s2_a_d     = s2_a_q;
    s2_x_d     = s2_x_q;
    s2_seg_d   = s2_seg_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_mode_d  = s1_mode_q;
      s2_tag_d   = s1_tag_q;
      s2_neg_d   = s1_neg_q;
      s2_a_d     = s1_a_q;
      s2_x_d     = s1_x_q;
      s2_seg_d   = sel_seg;
    end
  end

  always_comb begin
    s_r   = $signed({{(RW-AW){1'b0}}, eval_s});
    x_r   = $signed({{(RW-DATA_W){s2_x_q[DATA_W-1]}}, s2_x_q});
    t_r   = (s_r <<< 1) - ONE_R;
    res_r = x_r;
    case (s2_mode_q)
      MODE_SIGMOID: res_r = s2_neg_q ? (ONE_R - s_r) : s_r;
      MODE_TANH:    res_r = s2_neg_q ? -t_r : t_r;
      MODE_RELU:    res_r = s2_neg_q ? '0 : x_r;
      default:      res_r = x_r;
    endcase

    valid_out_d = valid_out_q;
    y_out_d     = y_out_q;
    tag_out_d   = tag_out_q;
    if (advance) begin
      valid_out_d = s2_valid_q;
      tag_out_d   = s2_tag_q;
      if (res_r > MAX_R) begin
        y_out_d = MAX_R[DATA_W-1:0];
      end else if (res_r < MIN_R) begin
        y_out_d = MIN_R[DATA_W-1:0];
      end else begin
        y_out_d = res_r[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_SIGMOID;
      s1_tag_q    <= '0;
      s1_neg_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_x_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= MODE_SIGMOID;
      s2_tag_q    <= '0;
      s2_neg_q    <= 1'b0;
      s2_a_q      <= '0;
      s2_x_q      <= '0;
      s2_seg_q    <= SEG_LOW;
      valid_out_q <= 1'b0;
      y_out_q     <= '0;
      tag_out_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_tag_q    <= s1_tag_d;
      s1_neg_q    <= s1_neg_d;
      s1_a_q      <= s1_a_d;
      s1_x_q      <= s1_x_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_tag_q    <= s2_tag_d;
      s2_neg_q    <= s2_neg_d;
      s2_a_q      <= s2_a_d;
      s2_x_q      <= s2_x_d;
      s2_seg_q    <= s2_seg_d;
      valid_out_q <= valid_out_d;
      y_out_q     <= y_out_d;
      tag_out_q   <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Self-checking bench for pwl_act_pipe against an arithmetic model of the activation rules.
module tb_pwl_act_pipe;

  localparam int DW  = 16;
  localparam int TW  = 8;
  localparam int ONE = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [1:0]    mode_in = '0;
  logic [DW-1:0] x_in = '0;
  logic [TW-1:0] tag_in = '0;
  logic          valid_out;
  logic          ready_out = 1'b1;
  logic [DW-1:0] y_out;
  logic [TW-1:0] tag_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] y;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];

  pwl_act_pipe #(
    .DATA_W (16),
    .FRAC_W (12),
    .TAG_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .mode_in   (mode_in),
    .x_in      (x_in),
    .tag_in    (tag_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .y_out     (y_out),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  // Sigmoid on a non-negative real-valued magnitude a (scaled by ONE).
  function automatic int sig_pos(input int a);
    if (a >= 5 * ONE) return ONE;
    else if (a * 8 >= 19 * ONE) return a / 32 + (27 * ONE) / 32;
    else if (a >= ONE) return a / 8 + (5 * ONE) / 8;
    else return a / 4 + ONE / 2;
  endfunction

  function automatic logic [DW-1:0] model(input int mode, input int x);
    int a;
    int r;
    a = (x < 0) ? -x : x;
    case (mode)
      0: r = (x < 0) ? ONE - sig_pos(a) : sig_pos(a);
      1: begin
        r = 2 * sig_pos(2 * a) - ONE;
        if (x < 0) r = -r;
      end
      2: r = (x < 0) ? 0 : x;
      default: r = x;
    endcase
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return DW'(r);
  endfunction

  function automatic logic [DW-1:0] pick_x();
    int unsigned r;
    int v;
    int edges[14] = '{0, 4096, 4095, 9728, 9727, 20480, 20479,
                      2048, 2047, 4864, 4863, 10240, 32767, -32768};
    r = $urandom_range(0, 2);
    if (r == 0) begin
      v = edges[$urandom_range(0, 13)];
      if ($urandom_range(0, 1) == 1) v = -v;
    end else if (r == 1) begin
      v = int'($urandom_range(0, 49151)) - 24576;
    end else begin
      v = int'($urandom_range(0, 65535));
    end
    return DW'(v);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    ready_out = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_out); end
    checks++;
    if (y_out !== '0) begin failures++; $display("FAIL reset_y got=%0d want=0", $signed(y_out)); end
    checks++;
    if (tag_out !== '0) begin failures++; $display("FAIL reset_tag got=%0d want=0", tag_out); end
    checks++;
    if (ready_in !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready_in); end
    ready_out = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int vm[13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 3, 2, 3};
    int vx[13] = '{0, 4096, -4096, 32767, -32768, 0, 4096, -4096, 20480, -1000, -1000, 1000, 1000};
    int vy[13] = '{2048, 3072, 1024, 4096, 0, 0, 3072, -3072, 4096, 0, -1000, 1000, 1000};
    logic [DW-1:0] want;
    logic [TW-1:0] wtag;
    ready_out = 1'b1;
    for (int i = 0; i < 13; i++) begin
      want = DW'(vy[i]);
      wtag = TW'(8'h40 + i);
      @(negedge clk);
      mode_in  = 2'(vm[i]);
      x_in     = DW'(vx[i]);
      tag_in   = wtag;
      valid_in = 1'b1;
      #1;
      checks++;
      if (ready_in !== 1'b1) begin failures++; $display("FAIL dir_ready[%0d] got=%b want=1", i, ready_in); end
      @(negedge clk);
      valid_in = 1'b0;
      checks++;
      if (valid_out !== 1'b0) begin failures++; $display("FAIL dir_lat1[%0d] valid got=%b want=0", i, valid_out); end
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin failures++; $display("FAIL dir_lat2[%0d] valid got=%b want=0", i, valid_out); end
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || y_out !== want || tag_out !== wtag) begin
        failures++;
        $display("FAIL dir_result[%0d] mode=%0d x=%0d got valid=%b y=%0d tag=%0d want valid=1 y=%0d tag=%0d",
                 i, vm[i], vx[i], valid_out, $signed(y_out), tag_out, $signed(want), wtag);
      end
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin failures++; $display("FAIL dir_drain[%0d] valid got=%b want=0", i, valid_out); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ey[8];
    ready_out = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 8) begin
        mode_in  = 2'(c % 4);
        x_in     = pick_x();
        tag_in   = TW'(c);
        valid_in = 1'b1;
        ey[c]    = model(c % 4, int'($signed(x_in)));
      end else begin
        valid_in = 1'b0;
      end
      #1;
      if (c < 8) begin
        checks++;
        if (ready_in !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b want=1", c, ready_in); end
      end
      checks++;
      if (c >= 3 && c <= 10) begin
        if (valid_out !== 1'b1 || y_out !== ey[c-3] || tag_out !== TW'(c - 3)) begin
          failures++;
          $display("FAIL b2b_out[%0d] got valid=%b y=%0d tag=%0d want valid=1 y=%0d tag=%0d",
                   c, valid_out, $signed(y_out), tag_out, $signed(ey[c-3]), c - 3);
        end
      end else if (valid_out !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle[%0d] valid got=%b want=0", c, valid_out);
      end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    exp_t e;
    sb.delete();
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      ready_out = !(c >= 4 && c < 8);
      if (sent < 8) begin
        mode_in  = 2'($urandom_range(0, 3));
        x_in     = pick_x();
        tag_in   = TW'(8'h80 + sent);
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      #1;
      if (c >= 4 && c < 8) begin
        checks++;
        if (ready_in !== 1'b0) begin failures++; $display("FAIL bp_ready_low[%0d] got=%b want=0", c, ready_in); end
      end
      if (valid_out === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL bp_spurious[%0d] y=%0d tag=%0d want no result", c, $signed(y_out), tag_out);
        end else begin
          if (y_out !== sb[0].y || tag_out !== sb[0].tag) begin
            failures++;
            $display("FAIL bp_out[%0d] got y=%0d tag=%0d want y=%0d tag=%0d",
                     c, $signed(y_out), tag_out, $signed(sb[0].y), sb[0].tag);
          end
          if (ready_out) begin
            void'(sb.pop_front());
            got++;
          end
        end
      end
      if (valid_in && ready_in) begin
        e.y   = model(int'(mode_in), int'($signed(x_in)));
        e.tag = tag_in;
        sb.push_back(e);
        sent++;
      end
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    checks++;
    if (got != 8 || sb.size() != 0) begin
      failures++;
      $display("FAIL bp_count got=%0d pending=%0d want got=8 pending=0", got, sb.size());
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL bp_dup valid got=%b want=0", valid_out); end
  endtask

  task automatic test_reset_midflight();
    ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mode_in  = 2'(i);
      x_in     = DW'(4096 + i);
      tag_in   = TW'(8'hC0 + i);
      valid_in = 1'b1;
    end
    @(negedge clk);
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1) begin failures++; $display("FAIL rstmid_prefill valid got=%b want=1", valid_out); end
    rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || y_out !== '0) begin
      failures++;
      $display("FAIL rstmid_clear got valid=%b y=%0d want valid=0 y=0", valid_out, $signed(y_out));
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_stale[%0d] got valid=%b y=%0d tag=%0d want valid=0", c, valid_out, $signed(y_out), tag_out);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    sb.delete();
    for (int c = 0; c < 430; c++) begin
      @(negedge clk);
      if (c < 400) begin
        valid_in  = ($urandom_range(0, 9) < 7);
        mode_in   = 2'($urandom_range(0, 3));
        x_in      = pick_x();
        tag_in    = TW'($urandom_range(0, 255));
        ready_out = ($urandom_range(0, 3) != 0);
      end else begin
        valid_in  = 1'b0;
        ready_out = 1'b1;
      end
      #1;
      checks++;
      if (ready_in !== (!valid_out || ready_out)) begin
        failures++;
        $display("FAIL rand_ready[%0d] got=%b want=%b", c, ready_in, (!valid_out || ready_out));
      end
      if (valid_out === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious[%0d] y=%0d tag=%0d want no result", c, $signed(y_out), tag_out);
        end else begin
          if (y_out !== sb[0].y || tag_out !== sb[0].tag) begin
            failures++;
            $display("FAIL rand_out[%0d] got y=%0d tag=%0d want y=%0d tag=%0d",
                     c, $signed(y_out), tag_out, $signed(sb[0].y), sb[0].tag);
          end
          if (ready_out) void'(sb.pop_front());
        end
      end
      if (valid_in && ready_in) begin
        e.y   = model(int'(mode_in), int'($signed(x_in)));
        e.tag = tag_in;
        sb.push_back(e);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rand_drain pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwl_act_pipe.md
PWL_ACT_PIPE -- requirements
Module: pwl_act_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed two's-complement data width of x_in and y_out.
REQ-002 SHALL have parameter FRAC_W, default 12, fractional bits; 1.0 = 2^FRAC_W (4096 at default).
REQ-003 SHALL have parameter TAG_W, default 8, width of the user sideband carried alongside each sample.
REQ-004 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, an input sample is presented.
REQ-007 SHALL have port ready_in, output, 1, the block accepts the sample this cycle.
REQ-008 SHALL have port mode_in, input, 2, per-sample function: 0 sigmoid, 1 tanh, 2 relu, 3 bypass.
REQ-009 SHALL have port x_in, input, DATA_W, signed Qm.FRAC_W operand.
REQ-010 SHALL have port tag_in, input, TAG_W, sideband returned unchanged with the result.
REQ-011 SHALL have port valid_out, output, 1, y_out/tag_out hold a result.
REQ-012 SHALL have port ready_out, input, 1, the downstream consumes the result this cycle.
REQ-013 SHALL have port y_out, output, DATA_W, signed result, same format as x_in.
REQ-014 SHALL have port tag_out, output, TAG_W, tag of the sample in y_out.

Function
REQ-015 SHALL transfer a sample on valid_in && ready_in, and a result on valid_out && ready_out.
REQ-016 SHALL be a 3-stage pipeline (S1 abs/sign/mode capture, S2 segment select, S3 slope-add, symmetry restore, saturate); latency 3 cycles with ready_out held high; throughput 1 sample/cycle.
REQ-017 SHALL use global stall: advance = !valid_out || ready_out; ready_in = advance; while stalled all stages, y_out, tag_out and valid_out hold.
REQ-018 SHALL not collapse bubbles; empty stages advance only when advance is high.
REQ-019 SHALL compute |x| in DATA_W+1 bits so x = -2^(DATA_W-1) is handled without overflow.
REQ-020 SHALL evaluate sigmoid on a = |x|: a>=5.0 -> 1.0; 2.375<=a<5.0 -> a/32 + 0.84375; 1.0<=a<2.375 -> a/8 + 0.625; a<1.0 -> a/4 + 0.5; breakpoints compared as lower-inclusive.
REQ-021 SHALL realise slopes by arithmetic right shift (truncation toward zero on the non-negative a); no multipliers.
REQ-022 SHALL return 1.0 - s for negative x in sigmoid mode.
REQ-023 SHALL compute tanh as 2*sigmoid(2|x|) - 1.0 with 2|x| in DATA_W+2 bits, negated for negative x.
REQ-024 SHALL output max(x,0) in relu mode and x unchanged in bypass mode, with the same 3-cycle latency.
REQ-025 SHALL saturate every result to the DATA_W signed range.
REQ-026 SHALL capture mode_in and tag_in with their sample; mode changes between consecutive samples take effect per sample with no flush.

Reset
REQ-027 SHALL, while rst is high, clear all stage valids, valid_out=0, y_out=0, tag_out=0, and ready_in=1.
REQ-028 SHALL discard in-flight samples on reset mid-operation; no result of a pre-reset sample appears afterwards.

Structure
REQ-029 SHALL place the mode enumeration and the breakpoint/intercept constants (expressed as functions of FRAC_W) in package pwl_act_pkg.
REQ-030 SHALL implement the per-segment select and shift-add evaluation in sub-module pwl_seg_eval, instantiated once and shared by sigmoid and tanh.

Verification (defaults DATA_W=16, FRAC_W=12)
REQ-031 SHALL check sigmoid: x=0 -> 2048, x=4096 -> 3072, x=-4096 -> 1024, x=32767 -> 4096, x=-32768 -> 0, each appearing exactly 3 cycles after acceptance.
REQ-032 SHALL check tanh: x=0 -> 0, x=4096 -> 3072, x=-4096 -> -3072, x=20480 -> 4096.
REQ-033 SHALL check relu/bypass: x=-1000 -> 0 / -1000; x=1000 -> 1000 / 1000.
REQ-034 SHALL check back-to-back stream of 8 samples with alternating mode_in and tags 0..7: results in order, tag_out matches, one per cycle.
REQ-035 SHALL check backpressure: ready_out low for 4 cycles with pipeline full -> ready_in low, outputs held stable, no loss or duplication after release.
REQ-036 SHALL check rst asserted with 3 samples in flight -> valid_out=0 and y_out=0 immediately; no stale result after rst deasserts.
